// File: rtl/seg_scan_blink_if.sv
// Digit/blink control inputs and multiplexed display outputs of the stopwatch display scanner.
interface seg_scan_blink_if;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       blink_en;
    logic       blink_sel;
    logic [6:0] dispDigit;
    logic [3:0] selector;

    modport master (
        output d0, d1, d2, d3, blink_en, blink_sel,
        input  dispDigit, selector
    );

    modport slave (
        input  d0, d1, d2, d3, blink_en, blink_sel,
        output dispDigit, selector
    );
endinterface

// File: rtl/seg_scan_blink.sv
// Scans four BCD digits onto a common-anode 7-segment display and blinks the
// field being adjusted (minutes or seconds).
module seg_scan_blink #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic           clk,
    input  logic           RESET_N,
    seg_scan_blink_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] presc_r;
    logic [1:0]    slot_r;
    logic [BW-1:0] bcnt_r;
    logic          bphase_r;
    logic [3:0]    selector_r;
    logic [6:0]    disp_r;

    logic          tick_s;
    logic [3:0]    digit_s;
    logic          in_field_s;
    logic          blank_s;
    logic [6:0]    seg_next_s;

    // Active-low segment pattern; non-BCD codes show a lone g segment.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Slot-entry decision: which digit is entered and whether it is blanked.
    always_comb begin
        tick_s = (presc_r == PW'(REFRESH_DIV - 1));
        case (slot_r)
            2'd0:    digit_s = bus.d0;
            2'd1:    digit_s = bus.d1;
            2'd2:    digit_s = bus.d2;
            2'd3:    digit_s = bus.d3;
            default: digit_s = 4'd0;
        endcase
        // blink_sel=0 selects the minutes pair (slots 2,3), 1 the seconds pair.
        if (bus.blink_sel) begin
            in_field_s = ~slot_r[1];
        end else begin
            in_field_s = slot_r[1];
        end
        blank_s = bus.blink_en & bphase_r & in_field_s;
        if (blank_s) begin
            seg_next_s = 7'b1111111;
        end else begin
            seg_next_s = bcd_to_seg(digit_s);
        end
    end

    // Refresh prescaler producing one tick per digit slot.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // slot_r names the slot entered on the next tick, so the first tick enters slot 0.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            slot_r <= 2'd0;
        end else if (tick_s) begin
            slot_r <= slot_r + 2'd1;
        end else begin
            slot_r <= slot_r;
        end
    end

    // Blink half-period counter; cleared whenever adjust mode is off so re-entry starts visible.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            bcnt_r   <= '0;
            bphase_r <= 1'b0;
        end else if (!bus.blink_en) begin
            bcnt_r   <= '0;
            bphase_r <= 1'b0;
        end else if (tick_s) begin
            if (bcnt_r == BW'(BLINK_DIV - 1)) begin
                bcnt_r   <= '0;
                bphase_r <= ~bphase_r;
            end else begin
                bcnt_r   <= bcnt_r + BW'(1);
                bphase_r <= bphase_r;
            end
        end else begin
            bcnt_r   <= bcnt_r;
            bphase_r <= bphase_r;
        end
    end

    // Anode and cathode registers load together at slot entry only.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            selector_r <= 4'b1111;
            disp_r     <= 7'b1111111;
        end else if (tick_s) begin
            selector_r <= ~(4'b0001 << slot_r);
            disp_r     <= seg_next_s;
        end else begin
            selector_r <= selector_r;
            disp_r     <= disp_r;
        end
    end

    assign bus.selector  = selector_r;
    assign bus.dispDigit = disp_r;
endmodule
